// File: rtl/input_event_scheduler.sv
// input_event_scheduler: 1 ms beat generator for the debouncers, plus per-input
// edge capture, one-deep pending event store and a round-robin serializer that
// emits one ASCII key event per grant over a valid/ready byte interface.
module input_event_scheduler #(
   parameter int unsigned N_INPUTS    = 4,
   parameter int unsigned CLK_FREQ_HZ = 48000000,
   parameter int unsigned BEAT_HZ     = 1000
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                enable_i,
   output logic                beat_1ms_o,
   input  logic [N_INPUTS-1:0] level_i,
   output logic [7:0]          event_data_o,
   output logic                event_valid_o,
   input  logic                event_ready_i,
   output logic [N_INPUTS-1:0] pending_o,
   output logic                overflow_o,
   input  logic                overflow_clr_i
);

   localparam int unsigned DIV = CLK_FREQ_HZ / BEAT_HZ;
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned IW  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state;
   state_t              state_d;
   logic [CW-1:0]       count;
   logic [N_INPUTS-1:0] level_q;
   logic [N_INPUTS-1:0] pol;
   logic [N_INPUTS-1:0] pol_d;
   logic [N_INPUTS-1:0] pending_d;
   logic [N_INPUTS-1:0] edges;
   logic [N_INPUTS-1:0] grant_mask;
   logic [IW-1:0]       last_grant;
   logic [IW-1:0]       grant_idx;
   logic [IW-1:0]       cand_idx;
   logic                grant;
   logic                found;
   logic                drop;
   logic [7:0]          char_d;

   // Prescaler: free-running 0..DIV-1 while enabled, strobe on the wrap
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count      <= '0;
         beat_1ms_o <= 1'b0;
      end else if (!enable_i) begin
         count      <= '0;
         beat_1ms_o <= 1'b0;
      end else begin
         beat_1ms_o <= (count == CW'(DIV - 1));
         count      <= (count == CW'(DIV - 1)) ? '0 : count + CW'(1);
      end
   end

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_d;
   end

   // Next state and round-robin grant search starting after the last grant
   always_comb begin
      state_d   = state;
      grant     = 1'b0;
      grant_idx = '0;
      found     = 1'b0;
      cand_idx  = '0;
      case (state)
         IDLE: begin
            if (|pending_o) begin
               for (int i = 1; i <= int'(N_INPUTS); i++) begin
                  cand_idx = IW'((int'(last_grant) + i) % int'(N_INPUTS));
                  if (!found && pending_o[cand_idx]) begin
                     found     = 1'b1;
                     grant_idx = cand_idx;
                  end
               end
               grant   = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (event_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Edge capture and pending update; an edge on the input being granted refills it
   always_comb begin
      grant_mask = '0;
      if (grant) grant_mask[grant_idx] = 1'b1;
      edges     = enable_i ? (level_i ^ level_q) : '0;
      pending_d = pending_o & ~grant_mask;
      pol_d     = pol;
      drop      = 1'b0;
      for (int k = 0; k < int'(N_INPUTS); k++) begin
         if (edges[k]) begin
            if (pending_d[k]) begin
               drop = 1'b1;
            end else begin
               pending_d[k] = 1'b1;
               pol_d[k]     = level_i[k];
            end
         end
      end
      char_d = pol[grant_idx] ? (8'h41 + 8'(grant_idx)) : (8'h61 + 8'(grant_idx));
   end

   // Level history, pending flags, polarity and sticky overflow
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         level_q    <= '0;
         pending_o  <= '0;
         pol        <= '0;
         overflow_o <= 1'b0;
      end else begin
         level_q   <= level_i;
         pending_o <= pending_d;
         pol       <= pol_d;
         if (drop)                overflow_o <= 1'b1;
         else if (overflow_clr_i) overflow_o <= 1'b0;
      end
   end

   // Output byte register: load on grant, hold until accepted
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         event_data_o  <= 8'h00;
         event_valid_o <= 1'b0;
         last_grant    <= IW'(N_INPUTS - 1);
      end else if (grant) begin
         event_data_o  <= char_d;
         event_valid_o <= 1'b1;
         last_grant    <= grant_idx;
      end else if (state == SEND && event_ready_i) begin
         event_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_input_event_scheduler.sv
// Testbench for input_event_scheduler: event-level reference model feeding a
// scoreboard queue, negedge monitor, directed scenarios and random traffic.
module tb_input_event_scheduler;

   localparam int N   = 4;
   localparam int DIV = 16;

   logic         clk;
   logic         rst;
   logic         enable;
   logic         beat;
   logic [N-1:0] lvl;
   logic [7:0]   data;
   logic         valid;
   logic         ready;
   logic [N-1:0] pending;
   logic         overflow;
   logic         clr;

   int errors = 0;
   int checks = 0;
   int beat_cnt = 0;

   // reference model state
   logic [N-1:0] m_pend;
   logic [N-1:0] m_pol;
   logic [N-1:0] m_prev;
   int           m_last;
   bit           m_busy;
   bit           m_ovf;
   bit           m_beat;
   int           m_run;
   bit           m_drop;
   int           m_g;
   int           m_c;
   logic [7:0]   exp_q[$];
   logic [7:0]   got[$];

   input_event_scheduler #(
      .N_INPUTS(N), .CLK_FREQ_HZ(16000), .BEAT_HZ(1000)
   ) dut (
      .clk_i(clk), .rst_i(rst), .enable_i(enable), .beat_1ms_o(beat),
      .level_i(lvl), .event_data_o(data), .event_valid_o(valid),
      .event_ready_i(ready), .pending_o(pending), .overflow_o(overflow),
      .overflow_clr_i(clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: one transfer in flight, one event slot per input,
   // round-robin order, beats every DIV enabled cycles.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pend = '0; m_pol = '0; m_prev = '0; m_last = N - 1;
         m_busy = 0; m_ovf = 0; m_beat = 0; m_run = 0;
         exp_q.delete();
      end else begin
         m_g = -1;
         if (m_busy) begin
            if (ready) m_busy = 0;
         end else begin
            for (int i = 1; i <= N; i++) begin
               m_c = (m_last + i) % N;
               if (m_g < 0 && m_pend[m_c]) m_g = m_c;
            end
            if (m_g >= 0) begin
               exp_q.push_back(m_pol[m_g] ? 8'(8'h41 + m_g) : 8'(8'h61 + m_g));
               m_pend[m_g] = 1'b0;
               m_last = m_g;
               m_busy = 1;
            end
         end
         m_drop = 0;
         for (int k = 0; k < N; k++) begin
            if (enable && lvl[k] != m_prev[k]) begin
               if (m_pend[k]) m_drop = 1;
               else begin
                  m_pend[k] = 1'b1;
                  m_pol[k]  = lvl[k];
               end
            end
         end
         m_prev = lvl;
         if (m_drop)   m_ovf = 1;
         else if (clr) m_ovf = 0;
         if (enable) m_run++;
         else        m_run = 0;
         m_beat = enable && (m_run % DIV == 0);
      end
   end

   // Monitor: compare outputs with the model; pop the scoreboard on each handshake
   always @(negedge clk) begin
      if (!rst) begin
         chk("valid", int'(valid), int'(m_busy));
         chk("pending", int'(pending), int'(m_pend));
         chk("overflow", int'(overflow), int'(m_ovf));
         chk("beat", int'(beat), int'(m_beat));
         if (beat) beat_cnt++;
         if (valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_event", int'(data), -1);
            end else begin
               chk("event_data", int'(data), int'(exp_q[0]));
               if (ready) begin
                  got.push_back(data);
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic chk_got(input string name, input string s);
      chk({name, "_count"}, got.size(), s.len());
      for (int i = 0; i < s.len() && i < got.size(); i++)
         chk(name, int'(got[i]), int'(s[i]));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      cycles(1);
   endtask

   initial begin
      rst = 1'b0; enable = 1'b1; ready = 1'b1; clr = 1'b0; lvl = '0;
      #1 rst = 1'b1;
      #2;
      chk("rst_valid", int'(valid), 0);
      chk("rst_data", int'(data), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_beat", int'(beat), 0);
      cycles(2);
      rst = 1'b0;

      // timebase
      cycles(40);
      enable = 1'b0;
      cycles(1);
      beat_cnt = 0;
      cycles(40);
      chk("beats_disabled", beat_cnt, 0);
      enable = 1'b1;
      beat_cnt = 0;
      cycles(64);
      @(negedge clk); #1;
      chk("beats_enabled", beat_cnt, 4);
      cycles(1);

      // single press / release on input 2
      got.delete();
      lvl[2] = 1'b1;
      cycles(6);
      lvl[2] = 1'b0;
      cycles(6);
      chk_got("single", "Cc");

      // round robin from reset state
      do_reset();
      got.delete();
      lvl = 4'hF;
      cycles(12);
      chk_got("rr_all", "ABCD");
      lvl = 4'h0;
      cycles(12);
      got.delete();
      lvl = 4'b1010;
      cycles(8);
      chk_got("rr_13", "BD");

      // backpressure
      got.delete();
      ready = 1'b0;
      lvl[0] = 1'b1;
      cycles(20);
      chk("bp_valid", int'(valid), 1);
      chk("bp_data", int'(data), 8'h41);
      chk("bp_none_taken", got.size(), 0);
      ready = 1'b1;
      cycles(4);
      chk_got("bp", "A");

      // overflow: input 0 releases, then presses again while still pending
      got.delete();
      ready = 1'b0;
      lvl[1] = 1'b0;
      cycles(3);
      lvl[0] = 1'b0;
      cycles(1);
      lvl[0] = 1'b1;
      cycles(2);
      chk("ovf_set", int'(overflow), 1);
      ready = 1'b1;
      cycles(8);
      chk_got("ovf", "ba");
      chk("ovf_sticky", int'(overflow), 1);
      clr = 1'b1;
      cycles(1);
      clr = 1'b0;
      cycles(1);
      chk("ovf_clr", int'(overflow), 0);

      // clear coinciding with a drop keeps overflow set
      ready = 1'b0;
      lvl[1] = 1'b1;
      cycles(3);
      lvl[0] = 1'b0;
      cycles(1);
      lvl[0] = 1'b1;
      clr = 1'b1;
      cycles(1);
      clr = 1'b0;
      cycles(1);
      chk("ovf_set_wins", int'(overflow), 1);
      ready = 1'b1;
      cycles(8);
      clr = 1'b1;
      cycles(1);
      clr = 1'b0;

      // async reset while an event is presented
      ready = 1'b0;
      lvl[2] = 1'b1;
      cycles(3);
      lvl[3] = 1'b0;
      cycles(2);
      chk("pre_rst_valid", int'(valid), 1);
      #1 rst = 1'b1;
      #1;
      chk("arst_valid", int'(valid), 0);
      chk("arst_pending", int'(pending), 0);
      chk("arst_overflow", int'(overflow), 0);
      chk("arst_beat", int'(beat), 0);
      chk("arst_data", int'(data), 0);
      @(posedge clk); #2;
      rst = 1'b0;
      ready = 1'b1;
      cycles(12);

      // random traffic in phases of decreasing sink readiness
      for (int p = 0; p < 4; p++) begin
         for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++)
               if ($urandom_range(7) == 0) lvl[k] = ~lvl[k];
            ready = ($urandom_range(7) >= 2 * p);
            clr   = ($urandom_range(40) == 0);
            if ($urandom_range(300) == 0) enable = ~enable;
            if ($urandom_range(900) == 0) rst = 1'b1;
            cycles(1);
            rst = 1'b0;
         end
      end

      // drain
      rst = 1'b0; enable = 1'b1; ready = 1'b1; clr = 1'b0;
      cycles(30);
      chk("drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
